// File: rtl/mem_uart_bridge_pkg.sv
// Shared definitions for the memory-over-UART bridge.
//   OP_RD / OP_WR : opcode field carried in the command header
//   state_t       : bridge FSM state encoding
//   CLK_DIV_DEF   : default clocks per UART bit (100 MHz / 115200)
//   hdr_byte      : builds the command header byte
//   byte_sel      : picks one byte out of a 32-bit word
package mem_uart_bridge_pkg;

   localparam int CLK_DIV_DEF = 868;

   localparam logic [1:0] OP_RD = 2'b01;
   localparam logic [1:0] OP_WR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_HDR,
      ST_SEND_ADDR,
      ST_SEND_DATA,
      ST_WAIT_RX,
      ST_DONE
   } state_t;

   function automatic logic [7:0] hdr_byte(input logic [1:0] op, input logic [1:0] len);
      return {op, 4'b0000, len};
   endfunction

   function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
      return 8'(word >> {idx, 3'b000});
   endfunction

endpackage

// File: rtl/mem_uart_bridge_if.sv
// MMU memory-port handshake bundle.
//   master : MMU side, drives requests, receives rack/din/wack
//   slave  : memory side (the bridge), answers with rack/din/wack
interface mem_uart_bridge_if;
   logic        re;
   logic [31:0] raddr;
   logic [1:0]  rlen;
   logic        rack;
   logic [31:0] din;
   logic        we;
   logic [31:0] waddr;
   logic [1:0]  wlen;
   logic [31:0] wdata;
   logic        wack;

   modport master (
      output re, raddr, rlen, we, waddr, wlen, wdata,
      input  rack, din, wack
   );

   modport slave (
      input  re, raddr, rlen, we, waddr, wlen, wdata,
      output rack, din, wack
   );
endinterface

// File: rtl/mem_uart_bridge_uart_phy.sv
// 8N1 UART bit engine for the bridge.
//   clk, rst           : system clock, async active-low reset
//   tx_start, tx_byte  : byte offered for transmit (level, held until tx_ack)
//   tx_ack             : byte taken this cycle; the next byte may be offered
//   tx_busy            : a frame is on the wire
//   txd                : serial out, idle high
//   rxd                : serial in, asynchronous
//   rx_valid, rx_byte  : one-cycle pulse with a correctly framed byte
module uart_phy
   import mem_uart_bridge_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_byte,
   output logic       tx_ack,
   output logic       tx_busy,
   output logic       txd,
   input  logic       rxd,
   output logic       rx_valid,
   output logic [7:0] rx_byte
);

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV / 2 - 1);

   logic [DW-1:0] tx_div;
   logic [3:0]    tx_bit;
   logic [8:0]    tx_sh;
   logic          tx_ready;

   // A new byte may be loaded on the last clock of the current stop bit,
   // so consecutive frames leave no idle gap.
   assign tx_ready = !tx_busy || (tx_div == '0 && tx_bit == 4'd0);
   assign tx_ack   = tx_start && tx_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_busy <= 1'b0;
         txd     <= 1'b1;
         tx_div  <= '0;
         tx_bit  <= 4'd0;
         tx_sh   <= '1;
      end else if (tx_ack) begin
         tx_busy <= 1'b1;
         txd     <= 1'b0;
         tx_sh   <= {1'b1, tx_byte};
         tx_bit  <= 4'd9;
         tx_div  <= DIV_LAST;
      end else if (tx_busy) begin
         if (tx_div != '0) begin
            tx_div <= tx_div - 1'b1;
         end else if (tx_bit == 4'd0) begin
            tx_busy <= 1'b0;
            txd     <= 1'b1;
         end else begin
            txd    <= tx_sh[0];
            tx_sh  <= {1'b1, tx_sh[8:1]};
            tx_bit <= tx_bit - 4'd1;
            tx_div <= DIV_LAST;
         end
      end
   end

   logic          rx_m, rx_s, rx_p;
   logic          rx_act;
   logic [DW-1:0] rx_div;
   logic [3:0]    rx_bit;
   logic [7:0]    rx_sh;

   // Start is a falling edge, not a low level: after a framing error the
   // line may still be low and must not be mistaken for a new start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_m     <= 1'b1;
         rx_s     <= 1'b1;
         rx_p     <= 1'b1;
         rx_act   <= 1'b0;
         rx_div   <= '0;
         rx_bit   <= 4'd0;
         rx_sh    <= 8'h00;
         rx_valid <= 1'b0;
         rx_byte  <= 8'h00;
      end else begin
         rx_m     <= rxd;
         rx_s     <= rx_m;
         rx_p     <= rx_s;
         rx_valid <= 1'b0;
         if (!rx_act) begin
            if (rx_p && !rx_s) begin
               rx_act <= 1'b1;
               rx_div <= HALF_LAST;
               rx_bit <= 4'd0;
            end
         end else if (rx_div != '0) begin
            rx_div <= rx_div - 1'b1;
         end else if (rx_bit == 4'd0) begin
            if (rx_s) begin
               rx_act <= 1'b0;
            end else begin
               rx_bit <= 4'd1;
               rx_div <= DIV_LAST;
            end
         end else if (rx_bit < 4'd9) begin
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_bit <= rx_bit + 4'd1;
            rx_div <= DIV_LAST;
         end else begin
            rx_act <= 1'b0;
            if (rx_s) begin
               rx_valid <= 1'b1;
               rx_byte  <= rx_sh;
            end
         end
      end
   end

endmodule

// File: rtl/mem_uart_bridge.sv
// Memory responder that forwards single MMU read/write requests to a host
// over an 8N1 UART and completes the four-phase rack/wack handshake.
//   clk, rst : system clock, async active-low reset
//   m        : MMU memory port (slave side)
//   txd, rxd : UART pins
//
// state        | meaning
// ST_IDLE      | waiting for a request; write wins over read
// ST_SEND_HDR  | header byte on the wire
// ST_SEND_ADDR | four address bytes, LSB first
// ST_SEND_DATA | write only, len+1 data bytes, LSB first
// ST_WAIT_RX   | collecting read data or the write ack byte
// ST_DONE      | ack high until the request drops
module mem_uart_bridge
   import mem_uart_bridge_pkg::*;
#(
   parameter int         CLK_DIV  = CLK_DIV_DEF,
   parameter logic [7:0] ACK_BYTE = 8'hAA
) (
   input  logic              clk,
   input  logic              rst,
   mem_uart_bridge_if.slave  m,
   output logic              txd,
   input  logic              rxd
);

   state_t      state;
   logic [1:0]  op;
   logic [1:0]  len;
   logic [31:0] addr;
   logic [31:0] data;
   logic [31:0] rd_buf;
   logic [31:0] rd_next;
   logic [31:0] din_q;
   logic [2:0]  cnt;
   logic        rack_q;
   logic        wack_q;
   logic        tx_start;
   logic [7:0]  tx_byte;
   logic        tx_ack;
   logic        tx_busy;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        req;
   logic        last;

   uart_phy #(.CLK_DIV(CLK_DIV)) u_phy (
      .clk      (clk),
      .rst      (rst),
      .tx_start (tx_start),
      .tx_byte  (tx_byte),
      .tx_ack   (tx_ack),
      .tx_busy  (tx_busy),
      .txd      (txd),
      .rxd      (rxd),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte)
   );

   assign m.rack = rack_q;
   assign m.wack = wack_q;
   assign m.din  = din_q;

   always_comb begin
      rd_next = rd_buf;
      rd_next[{cnt[1:0], 3'b000} +: 8] = rx_byte;
   end

   assign req  = (op == OP_RD) ? m.re : m.we;
   assign last = (cnt == {1'b0, len});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         op       <= OP_RD;
         len      <= 2'd0;
         addr     <= '0;
         data     <= '0;
         rd_buf   <= '0;
         din_q    <= '0;
         cnt      <= 3'd0;
         rack_q   <= 1'b0;
         wack_q   <= 1'b0;
         tx_start <= 1'b0;
         tx_byte  <= 8'h00;
      end else begin
         case (state)
            ST_IDLE: begin
               if (m.we) begin
                  op       <= OP_WR;
                  len      <= m.wlen;
                  addr     <= m.waddr;
                  data     <= m.wdata;
                  tx_byte  <= hdr_byte(OP_WR, m.wlen);
                  tx_start <= 1'b1;
                  state    <= ST_SEND_HDR;
               end else if (m.re) begin
                  op       <= OP_RD;
                  len      <= m.rlen;
                  addr     <= m.raddr;
                  rd_buf   <= '0;
                  tx_byte  <= hdr_byte(OP_RD, m.rlen);
                  tx_start <= 1'b1;
                  state    <= ST_SEND_HDR;
               end
            end
            ST_SEND_HDR: begin
               if (tx_ack) begin
                  tx_byte <= addr[7:0];
                  cnt     <= 3'd0;
                  state   <= ST_SEND_ADDR;
               end
            end
            // tx_start low here means the last byte is loaded and we only
            // wait for its stop bit to finish before listening.
            ST_SEND_ADDR: begin
               if (tx_start) begin
                  if (tx_ack) begin
                     if (cnt == 3'd3) begin
                        if (op == OP_WR) begin
                           tx_byte <= data[7:0];
                           cnt     <= 3'd0;
                           state   <= ST_SEND_DATA;
                        end else begin
                           tx_start <= 1'b0;
                        end
                     end else begin
                        cnt     <= cnt + 3'd1;
                        tx_byte <= byte_sel(addr, cnt[1:0] + 2'd1);
                     end
                  end
               end else if (!tx_busy) begin
                  cnt   <= 3'd0;
                  state <= ST_WAIT_RX;
               end
            end
            ST_SEND_DATA: begin
               if (tx_start) begin
                  if (tx_ack) begin
                     if (last) begin
                        tx_start <= 1'b0;
                     end else begin
                        cnt     <= cnt + 3'd1;
                        tx_byte <= byte_sel(data, cnt[1:0] + 2'd1);
                     end
                  end
               end else if (!tx_busy) begin
                  cnt   <= 3'd0;
                  state <= ST_WAIT_RX;
               end
            end
            ST_WAIT_RX: begin
               if (rx_valid) begin
                  if (op == OP_RD) begin
                     rd_buf <= rd_next;
                     if (last) begin
                        din_q  <= rd_next;
                        rack_q <= 1'b1;
                        state  <= ST_DONE;
                     end else begin
                        cnt <= cnt + 3'd1;
                     end
                  end else if (rx_byte == ACK_BYTE) begin
                     wack_q <= 1'b1;
                     state  <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (!req) begin
                  rack_q <= 1'b0;
                  wack_q <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_uart_bridge.sv
// Directed bench for mem_uart_bridge: a UART decoder on txd checks command
// bytes against an expected-byte queue, and an ack monitor checks each
// rack/wack rising edge (and din) against an expected-completion queue.
module tb_mem_uart_bridge;

   localparam int CD = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rxd;
   logic txd;

   mem_uart_bridge_if mif();

   mem_uart_bridge #(.CLK_DIV(CD), .ACK_BYTE(8'hAA)) dut (
      .clk (clk),
      .rst (rst),
      .m   (mif),
      .txd (txd),
      .rxd (rxd)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_rd;
      logic [31:0] data;
   } ack_t;

   int          checks = 0;
   int          errors = 0;
   int          rst_count = 0;
   logic [7:0]  exp_tx[$];
   ack_t        exp_ack[$];

   always @(negedge rst) rst_count++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_ack(input bit is_rd, input logic [31:0] d);
      ack_t e;
      e.is_rd = is_rd;
      e.data  = d;
      exp_ack.push_back(e);
   endtask

   // txd decoder
   initial begin
      logic [7:0] b;
      int         r0;
      logic       stop;
      forever begin
         @(negedge txd);
         r0 = rst_count;
         repeat (CD / 2) @(posedge clk);
         #1;
         if (txd !== 1'b0) continue;
         for (int i = 0; i < 8; i++) begin
            repeat (CD) @(posedge clk);
            #1;
            b[i] = txd;
         end
         repeat (CD) @(posedge clk);
         #1;
         stop = txd;
         if (rst_count != r0 || rst !== 1'b1) continue;
         if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got %h expected no byte", b);
         end else begin
            check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
         end
         check("tx_stop", 32'(stop), 32'd1);
      end
   end

   // ack monitor
   initial begin
      logic pr;
      logic pw;
      ack_t e;
      pr = 1'b0;
      pw = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst === 1'b1 && ((mif.rack === 1'b1 && !pr) || (mif.wack === 1'b1 && !pw))) begin
            if (exp_ack.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ack_unexpected: got rack=%b wack=%b expected none", mif.rack, mif.wack);
            end else begin
               e = exp_ack.pop_front();
               check("ack_is_read", 32'(mif.rack), 32'(e.is_rd));
               if (e.is_rd) check("rd_din", mif.din, e.data);
            end
         end
         pr = (mif.rack === 1'b1);
         pw = (mif.wack === 1'b1);
      end
   end

   task automatic host_byte(input logic [7:0] b, input bit good_stop);
      rxd = 1'b0;
      cyc(CD);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         cyc(CD);
      end
      rxd = good_stop;
      cyc(CD);
      rxd = 1'b1;
      if (!good_stop) cyc(CD);
   endtask

   task automatic wait_tx_drain(input int budget);
      int n;
      n = 0;
      while (exp_tx.size() != 0 && n < budget) begin
         cyc(1);
         n++;
      end
      checks++;
      if (exp_tx.size() != 0) begin
         errors++;
         $display("FAIL tx_drain: got %0d bytes outstanding expected 0", exp_tx.size());
         exp_tx.delete();
      end
      cyc(2 * CD);
   endtask

   task automatic wait_ack(input bit is_rd, input int budget, input string name);
      int   n;
      logic a;
      n = 0;
      a = is_rd ? mif.rack : mif.wack;
      while (a !== 1'b1 && n < budget) begin
         cyc(1);
         n++;
         a = is_rd ? mif.rack : mif.wack;
      end
      check(name, 32'(a), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic txd_ok;
      rst       = 1'b0;
      rxd       = 1'b1;
      mif.re    = 1'b0;
      mif.raddr = '0;
      mif.rlen  = '0;
      mif.we    = 1'b0;
      mif.waddr = '0;
      mif.wlen  = '0;
      mif.wdata = '0;
      cyc(3);
      check("rst_rack", 32'(mif.rack), 32'd0);
      check("rst_wack", 32'(mif.wack), 32'd0);
      check("rst_din", mif.din, 32'd0);
      check("rst_txd", 32'(txd), 32'd1);
      rst = 1'b1;
      cyc(2);

      // 4-byte read
      exp_tx.push_back(8'h43); exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
      exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
      push_ack(1'b1, 32'h12345678);
      mif.raddr = 32'h00001234; mif.rlen = 2'd3; mif.re = 1'b1;
      cyc(1);
      mif.raddr = 32'hFFFFFFFF; mif.rlen = 2'd0;
      wait_tx_drain(100 * CD);
      host_byte(8'h78, 1'b1); host_byte(8'h56, 1'b1);
      host_byte(8'h34, 1'b1); host_byte(8'h12, 1'b1);
      wait_ack(1'b1, 4 * CD, "rack_rise_4b");
      cyc(3);
      check("rack_held", 32'(mif.rack), 32'd1);
      mif.re = 1'b0;
      cyc(1);
      check("rack_fall_4b", 32'(mif.rack), 32'd0);
      check("din_hold_4b", mif.din, 32'h12345678);
      cyc(2);

      // 1-byte read, upper bytes zero
      exp_tx.push_back(8'h40); exp_tx.push_back(8'h20); exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
      push_ack(1'b1, 32'h000000AB);
      mif.raddr = 32'h00000020; mif.rlen = 2'd0; mif.re = 1'b1;
      wait_tx_drain(100 * CD);
      host_byte(8'hAB, 1'b1);
      wait_ack(1'b1, 4 * CD, "rack_rise_1b");
      mif.re = 1'b0;
      cyc(1);
      check("rack_fall_1b", 32'(mif.rack), 32'd0);
      check("din_hold_1b", mif.din, 32'h000000AB);
      cyc(2);

      // 2-byte write, wrong ack byte first
      exp_tx.push_back(8'h81); exp_tx.push_back(8'h10); exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h00); exp_tx.push_back(8'h00); exp_tx.push_back(8'hEF);
      exp_tx.push_back(8'hBE);
      push_ack(1'b0, 32'h0);
      mif.waddr = 32'h00000010; mif.wlen = 2'd1; mif.wdata = 32'h1234BEEF; mif.we = 1'b1;
      cyc(1);
      mif.wdata = 32'h00000000; mif.waddr = 32'hFFFFFFFF;
      wait_tx_drain(100 * CD);
      host_byte(8'h55, 1'b1);
      cyc(3 * CD);
      check("wack_after_bad_ack", 32'(mif.wack), 32'd0);
      host_byte(8'hAA, 1'b1);
      wait_ack(1'b0, 4 * CD, "wack_rise");
      mif.we = 1'b0;
      cyc(1);
      check("wack_fall", 32'(mif.wack), 32'd0);
      check("din_kept_after_wr", mif.din, 32'h000000AB);
      cyc(2);

      // simultaneous read and write: write first
      exp_tx.push_back(8'h80); exp_tx.push_back(8'h44); exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h00); exp_tx.push_back(8'h00); exp_tx.push_back(8'h77);
      push_ack(1'b0, 32'h0);
      push_ack(1'b1, 32'h0000003C);
      mif.waddr = 32'h00000044; mif.wlen = 2'd0; mif.wdata = 32'h00000077; mif.we = 1'b1;
      mif.raddr = 32'h00000088; mif.rlen = 2'd0; mif.re = 1'b1;
      wait_tx_drain(100 * CD);
      host_byte(8'hAA, 1'b1);
      wait_ack(1'b0, 4 * CD, "wack_rise_arb");
      txd_ok = 1'b1;
      for (int i = 0; i < 2 * CD; i++) begin
         cyc(1);
         if (txd !== 1'b1 || mif.rack !== 1'b0) txd_ok = 1'b0;
      end
      check("no_read_while_wack", 32'(txd_ok), 32'd1);
      exp_tx.push_back(8'h40); exp_tx.push_back(8'h88); exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
      mif.we = 1'b0;
      cyc(1);
      check("wack_fall_arb", 32'(mif.wack), 32'd0);
      wait_tx_drain(100 * CD);
      host_byte(8'h3C, 1'b1);
      wait_ack(1'b1, 4 * CD, "rack_rise_arb");
      mif.re = 1'b0;
      cyc(3);

      // framing error mid-read
      exp_tx.push_back(8'h41); exp_tx.push_back(8'h99); exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
      push_ack(1'b1, 32'h00004321);
      mif.raddr = 32'h00000099; mif.rlen = 2'd1; mif.re = 1'b1;
      wait_tx_drain(100 * CD);
      host_byte(8'h5A, 1'b0);
      host_byte(8'h21, 1'b1);
      cyc(2 * CD);
      check("no_rack_after_1_good", 32'(mif.rack), 32'd0);
      host_byte(8'h43, 1'b1);
      wait_ack(1'b1, 4 * CD, "rack_rise_ferr");
      mif.re = 1'b0;
      cyc(3);

      // reset during address bytes
      exp_tx.push_back(8'h41);
      mif.raddr = 32'h00000000; mif.rlen = 2'd1; mif.re = 1'b1;
      cyc(12 * CD + CD / 2 + 1);
      check("txd_low_in_addr", 32'(txd), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_mid_txd", 32'(txd), 32'd1);
      check("rst_mid_rack", 32'(mif.rack), 32'd0);
      check("rst_mid_wack", 32'(mif.wack), 32'd0);
      mif.re = 1'b0;
      cyc(10 * CD);
      exp_tx.delete();
      rst = 1'b1;
      cyc(2);
      exp_tx.push_back(8'h41); exp_tx.push_back(8'h20); exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
      push_ack(1'b1, 32'h000011CD);
      mif.raddr = 32'h00000020; mif.rlen = 2'd1; mif.re = 1'b1;
      wait_tx_drain(100 * CD);
      host_byte(8'hCD, 1'b1);
      host_byte(8'h11, 1'b1);
      wait_ack(1'b1, 4 * CD, "rack_rise_after_rst");
      mif.re = 1'b0;
      cyc(1);
      check("rack_fall_after_rst", 32'(mif.rack), 32'd0);

      cyc(4);
      check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
      check("ack_queue_empty", 32'(exp_ack.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
